fft_cbfp_denorm: RTL and testbench

FFT_CBFP_DENORM -- requirements
Module: fft_cbfp_denorm

---
 rtl/fft_cbfp_pkg.sv | 16 +
 rtl/fft_cbfp_idx_fifo.sv | 90 +++++++++
 rtl/fft_cbfp_denorm.sv | 145 ++++++++++++++
 tb/tb_fft_cbfp_denorm.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_cbfp_pkg.sv
// Shared CBFP definitions: exponent width, mantissa and restore widths, and
// the packed exponent pair. The block normalizer uses the same package.
package fft_cbfp_pkg;

    localparam int CBFP_IDX_W = 5;                  // block exponent width
    localparam int MANT_W     = 12;                 // normalized mantissa width
    localparam int WIDE_W     = 25;                 // restore working width
    localparam int WIDE_LSH   = WIDE_W - MANT_W;    // mantissa pre-shift (13)

    // Exponent pair for one block: h covers the upper lanes, l the lower lanes
    typedef struct packed {
        logic [CBFP_IDX_W-1:0] h;
        logic [CBFP_IDX_W-1:0] l;
    } idx_pair_t;

endpackage

// File: rtl/fft_cbfp_idx_fifo.sv
// Exponent-pair FIFO between the CBFP normalizer and the denormalizer.
// No bypass: a pop on an empty FIFO underflows even if a push arrives in the
// same cycle. A push on a full FIFO succeeds only when a pop frees a slot.
module fft_cbfp_idx_fifo
    import fft_cbfp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  idx_pair_t                i_push_data,
    input  logic                     i_pop,
    output idx_pair_t                o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_cnt,
    output logic                     o_err_ovf,
    output logic                     o_err_unf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    idx_pair_t          r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err_ovf;
    logic               r_err_unf;

    logic               w_full;
    logic               w_empty;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_full    = (r_cnt == CNT_W'(DEPTH));
    assign w_empty   = (r_cnt == '0);
    assign w_do_pop  = i_pop & ~w_empty;
    // A full FIFO still accepts a push when the same cycle pops the head
    assign w_do_push = i_push & (~w_full | w_do_pop);

    // Storage write
    // NOTE: the storage array has no reset; pointers and count define which
    // entries are live, so clearing them on reset discards every stored pair.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, occupancy and sticky error flags
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cnt     <= '0;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (i_push && !w_do_push) begin
                r_err_ovf <= 1'b1;
            end
            if (i_pop && w_empty) begin
                r_err_unf <= 1'b1;
            end
        end
    end

    // Underflowing pops read exponent 0 for both halves
    assign o_pop_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_cnt      = r_cnt;
    assign o_err_ovf  = r_err_ovf;
    assign o_err_unf  = r_err_unf;

endmodule

// File: rtl/fft_cbfp_denorm.sv
// CBFP denormalizer: restores block-floating-point mantissas to fixed point
// using the exponent pair popped from the index FIFO. Two-cycle latency,
// one block per cycle.
// Build option CBFP_DENORM_SAT_EN: saturate restored samples to OUT_W bits
// instead of keeping the low OUT_W bits.
module fft_cbfp_denorm
    import fft_cbfp_pkg::*;
#(
    parameter int ARRAY      = 16,
    parameter int OUT_W      = 16,
    parameter int SHIFT_BASE = 9,
    parameter int IDX_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          idx_val,
    input  logic [CBFP_IDX_W-1:0]         index_h,
    input  logic [CBFP_IDX_W-1:0]         index_l,
    input  logic                          val_in,
    input  logic signed [MANT_W-1:0]      re_in [ARRAY],
    input  logic signed [MANT_W-1:0]      im_in [ARRAY],
    output logic                          val_out,
    output logic signed [OUT_W-1:0]       re_out [ARRAY],
    output logic signed [OUT_W-1:0]       im_out [ARRAY],
    output logic                          idx_full,
    output logic                          idx_empty,
    output logic [$clog2(IDX_DEPTH):0]    idx_cnt,
    output logic                          err_ovf,
    output logic                          err_unf
);

    localparam int SH_W = 7;

`ifdef CBFP_DENORM_SAT_EN
    localparam logic signed [WIDE_W-1:0] SAT_MAX = WIDE_W'(2**(OUT_W-1) - 1);
    localparam logic signed [WIDE_W-1:0] SAT_MIN = -SAT_MAX - WIDE_W'(1);
`endif

    // Restore one mantissa: place it at the top of the wide word, then shift
    // right arithmetically by exponent plus the fixed base shift.
    function automatic logic signed [OUT_W-1:0] f_restore(
        input logic signed [MANT_W-1:0]     mant,
        input logic        [CBFP_IDX_W-1:0] k
    );
        logic signed [WIDE_W-1:0] wide;
        logic signed [WIDE_W-1:0] tmp;
        logic        [SH_W-1:0]   sh;
        // Sign-extending to WIDE_W and shifting left by WIDE_LSH leaves
        // exactly the mantissa in the top bits over a zero tail
        wide = {mant, {WIDE_LSH{1'b0}}};
        sh   = SH_W'(k) + SH_W'(SHIFT_BASE);
        // Shifts past the sign bit all collapse to 0 / -1
        if (sh > SH_W'(WIDE_W - 1)) begin
            sh = SH_W'(WIDE_W - 1);
        end
        tmp = wide >>> sh;
`ifdef CBFP_DENORM_SAT_EN
        if (tmp > SAT_MAX) begin
            tmp = SAT_MAX;
        end else if (tmp < SAT_MIN) begin
            tmp = SAT_MIN;
        end
`endif
        return OUT_W'(tmp);
    endfunction

    idx_pair_t                  w_push_pair;
    idx_pair_t                  w_pop_pair;

    logic                       r_s1_val;
    idx_pair_t                  r_s1_k;
    logic signed [MANT_W-1:0]   r_s1_re [ARRAY];
    logic signed [MANT_W-1:0]   r_s1_im [ARRAY];

    logic signed [OUT_W-1:0]    w_re_res [ARRAY];
    logic signed [OUT_W-1:0]    w_im_res [ARRAY];

    assign w_push_pair = '{h: index_h, l: index_l};

    fft_cbfp_idx_fifo #(
        .DEPTH        (IDX_DEPTH)
    ) u_idx_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (idx_val),
        .i_push_data  (w_push_pair),
        .i_pop        (val_in),
        .o_pop_data   (w_pop_pair),
        .o_full       (idx_full),
        .o_empty      (idx_empty),
        .o_cnt        (idx_cnt),
        .o_err_ovf    (err_ovf),
        .o_err_unf    (err_unf)
    );

    // Stage 1: capture mantissas together with the popped exponent pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_val <= 1'b0;
            r_s1_k   <= '0;
            for (int i = 0; i < ARRAY; i++) begin
                r_s1_re[i] <= '0;
                r_s1_im[i] <= '0;
            end
        end else begin
            r_s1_val <= val_in;
            if (val_in) begin
                r_s1_k <= w_pop_pair;
                for (int i = 0; i < ARRAY; i++) begin
                    r_s1_re[i] <= re_in[i];
                    r_s1_im[i] <= im_in[i];
                end
            end
        end
    end

    // Stage 2 datapath: lower half of the lanes uses k_l, upper half k_h
    // NOTE: every element is assigned on each pass, so no latch can form.
    always_comb begin
        for (int i = 0; i < ARRAY; i++) begin
            w_re_res[i] = f_restore(r_s1_re[i], (i < ARRAY/2) ? r_s1_k.l : r_s1_k.h);
            w_im_res[i] = f_restore(r_s1_im[i], (i < ARRAY/2) ? r_s1_k.l : r_s1_k.h);
        end
    end

    // Stage 2 output registers; samples hold while no block is valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_out <= 1'b0;
            for (int i = 0; i < ARRAY; i++) begin
                re_out[i] <= '0;
                im_out[i] <= '0;
            end
        end else begin
            val_out <= r_s1_val;
            if (r_s1_val) begin
                for (int i = 0; i < ARRAY; i++) begin
                    re_out[i] <= w_re_res[i];
                    im_out[i] <= w_im_res[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_cbfp_denorm.sv
// Scoreboard bench for fft_cbfp_denorm. Two instances share stimulus: the
// default build (SHIFT_BASE=9) and one with SHIFT_BASE=8 to reach saturation.
module tb_fft_cbfp_denorm;

    localparam int ARRAY     = 16;
    localparam int OUT_W     = 16;
    localparam int IDX_DEPTH = 4;
    localparam int VW        = ARRAY * OUT_W;

    typedef struct {
        int          due;
        logic [VW-1:0] re;
        logic [VW-1:0] im;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst;
    logic                      idx_val;
    logic [4:0]                index_h;
    logic [4:0]                index_l;
    logic                      val_in;
    logic signed [11:0]        re_in [ARRAY];
    logic signed [11:0]        im_in [ARRAY];

    logic                      val_out0, val_out8;
    logic signed [OUT_W-1:0]   re_out0 [ARRAY];
    logic signed [OUT_W-1:0]   im_out0 [ARRAY];
    logic signed [OUT_W-1:0]   re_out8 [ARRAY];
    logic signed [OUT_W-1:0]   im_out8 [ARRAY];
    logic                      idx_full0, idx_empty0, err_ovf0, err_unf0;
    logic                      idx_full8, idx_empty8, err_ovf8, err_unf8;
    logic [$clog2(IDX_DEPTH):0] idx_cnt0, idx_cnt8;

    logic [VW-1:0] p_re0, p_im0, p_re8, p_im8;

    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    exp_t        sq0[$];
    exp_t        sq8[$];
    logic [9:0]  idx_q[$];
    bit          m_ovf, m_unf;
    logic [VW-1:0] last_re [2];
    logic [VW-1:0] last_im [2];

    fft_cbfp_denorm #(
        .ARRAY(ARRAY), .OUT_W(OUT_W), .SHIFT_BASE(9), .IDX_DEPTH(IDX_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .idx_val(idx_val), .index_h(index_h), .index_l(index_l),
        .val_in(val_in), .re_in(re_in), .im_in(im_in), .val_out(val_out0),
        .re_out(re_out0), .im_out(im_out0), .idx_full(idx_full0), .idx_empty(idx_empty0),
        .idx_cnt(idx_cnt0), .err_ovf(err_ovf0), .err_unf(err_unf0)
    );

    fft_cbfp_denorm #(
        .ARRAY(ARRAY), .OUT_W(OUT_W), .SHIFT_BASE(8), .IDX_DEPTH(IDX_DEPTH)
    ) dut_sb8 (
        .clk(clk), .rst(rst), .idx_val(idx_val), .index_h(index_h), .index_l(index_l),
        .val_in(val_in), .re_in(re_in), .im_in(im_in), .val_out(val_out8),
        .re_out(re_out8), .im_out(im_out8), .idx_full(idx_full8), .idx_empty(idx_empty8),
        .idx_cnt(idx_cnt8), .err_ovf(err_ovf8), .err_unf(err_unf8)
    );

    always_comb begin
        p_re0 = '0; p_im0 = '0; p_re8 = '0; p_im8 = '0;
        for (int i = 0; i < ARRAY; i++) begin
            p_re0[i*OUT_W +: OUT_W] = re_out0[i];
            p_im0[i*OUT_W +: OUT_W] = im_out0[i];
            p_re8[i*OUT_W +: OUT_W] = re_out8[i];
            p_im8[i*OUT_W +: OUT_W] = im_out8[i];
        end
    end

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
        n_total++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    // Reference restore: mant * 2^13 / 2^(k+sb), floored, then wrapped or clamped
    function automatic logic [VW-1:0] model_vec(input int sb, input int kh, input int kl, input bit use_im);
        logic [VW-1:0] v;
        longint w, t;
        int k;
        v = '0;
        for (int i = 0; i < ARRAY; i++) begin
            k = (i < ARRAY/2) ? kl : kh;
            w = use_im ? longint'(im_in[i]) : longint'(re_in[i]);
            w = w * 8192;
            t = w >>> (k + sb);
`ifdef CBFP_DENORM_SAT_EN
            if (t > 32767) t = 32767;
            else if (t < -32768) t = -32768;
`endif
            v[i*OUT_W +: OUT_W] = t[OUT_W-1:0];
        end
        return v;
    endfunction

    task automatic set_mant(input logic [11:0] re_v, input logic [11:0] im_v);
        for (int i = 0; i < ARRAY; i++) begin
            re_in[i] = re_v;
            im_in[i] = im_v;
        end
    endtask

    // Drive one cycle of stimulus and record what the DUTs must produce
    task automatic drive(input logic iv, input int h, input int l, input logic vi);
        logic [9:0] pair;
        bit was_full, popped;
        exp_t e;
        idx_val = iv; index_h = 5'(h); index_l = 5'(l); val_in = vi;
        was_full = (idx_q.size() == IDX_DEPTH);
        popped = 0;
        pair = '0;
        if (vi) begin
            if (idx_q.size() > 0) begin
                pair = idx_q.pop_front();
                popped = 1;
            end else begin
                m_unf = 1;
            end
            e.due = cyc + 2;
            e.re = model_vec(9, int'(pair[9:5]), int'(pair[4:0]), 0);
            e.im = model_vec(9, int'(pair[9:5]), int'(pair[4:0]), 1);
            sq0.push_back(e);
            e.re = model_vec(8, int'(pair[9:5]), int'(pair[4:0]), 0);
            e.im = model_vec(8, int'(pair[9:5]), int'(pair[4:0]), 1);
            sq8.push_back(e);
        end
        if (iv) begin
            if (!was_full || popped) idx_q.push_back({5'(h), 5'(l)});
            else m_ovf = 1;
        end
        @(negedge clk);
        idx_val = 0; val_in = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        rst = 1; idx_val = 0; val_in = 0;
        sq0.delete(); sq8.delete(); idx_q.delete();
        m_ovf = 0; m_unf = 0;
        repeat (n) @(negedge clk);
        rst = 0;
    endtask

    task automatic chk_status(input string tag);
        check({tag, "_cnt"},   idx_cnt0,   idx_q.size());
        check({tag, "_full"},  idx_full0,  idx_q.size() == IDX_DEPTH);
        check({tag, "_empty"}, idx_empty0, idx_q.size() == 0);
        check({tag, "_ovf"},   err_ovf0,   m_ovf);
        check({tag, "_unf"},   err_unf0,   m_unf);
    endtask

    // Compare one DUT against its scoreboard queue for this cycle
    task automatic mon(input int d, input logic v, input logic [VW-1:0] re, input logic [VW-1:0] im);
        exp_t e;
        bit have;
        have = 0;
        if (d == 0) begin
            while (sq0.size() > 0 && sq0[0].due < cyc) void'(sq0.pop_front());
            if (sq0.size() > 0 && sq0[0].due == cyc) begin e = sq0.pop_front(); have = 1; end
        end else begin
            while (sq8.size() > 0 && sq8[0].due < cyc) void'(sq8.pop_front());
            if (sq8.size() > 0 && sq8[0].due == cyc) begin e = sq8.pop_front(); have = 1; end
        end
        check($sformatf("val_out%0d@%0d", d, cyc), v, have);
        if (have && v) begin
            check($sformatf("re%0d@%0d", d, cyc), re, e.re);
            check($sformatf("im%0d@%0d", d, cyc), im, e.im);
            last_re[d] = re;
            last_im[d] = im;
        end else if (!v) begin
            check($sformatf("hold_re%0d@%0d", d, cyc), re, last_re[d]);
            check($sformatf("hold_im%0d@%0d", d, cyc), im, last_im[d]);
        end
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst) begin
            last_re[0] = '0; last_im[0] = '0;
            last_re[1] = '0; last_im[1] = '0;
        end
        mon(0, val_out0, p_re0, p_im0);
        mon(1, val_out8, p_re8, p_im8);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1; idx_val = 0; val_in = 0; index_h = 0; index_l = 0;
        m_ovf = 0; m_unf = 0;
        set_mant(12'h000, 12'h000);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_val_out", val_out0, 1'b0);
        check("rst_re", p_re0, '0);
        check("rst_im", p_im0, '0);
        chk_status("rst");
        rst = 0;
        @(negedge clk);

        // Basic restore: k_l=1 for lane 0, k_h=3 for lane 8
        set_mant(12'h000, 12'h000);
        re_in[0] = 12'h400; re_in[8] = 12'h400;
        im_in[3] = 12'hC00; im_in[12] = 12'h123;
        drive(1, 3, 1, 0);
        drive(0, 0, 0, 1);
        @(negedge clk);
        check("basic_re0", p_re0[0 +: 16], 16'h2000);
        check("basic_re8", p_re0[8*16 +: 16], 16'h0800);
        idle(2);

        // Extreme shift: all lanes k=24
        set_mant(12'hFFF, 12'h7FF);
        drive(1, 24, 24, 0);
        drive(0, 0, 0, 1);
        @(negedge clk);
        check("ext_neg_re0", p_re0[0 +: 16], 16'hFFFF);
        check("ext_neg_re15", p_re0[15*16 +: 16], 16'hFFFF);
        check("ext_pos_im0", p_im0[0 +: 16], 16'h0000);
        idle(2);

        // Saturation edge on the SHIFT_BASE=8 instance
        set_mant(12'h7FF, 12'h800);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 1);
        @(negedge clk);
`ifdef CBFP_DENORM_SAT_EN
        check("sat_re", p_re8[0 +: 16], 16'h7FFF);
        check("sat_im", p_im8[0 +: 16], 16'h8000);
`else
        check("wrap_re", p_re8[0 +: 16], 16'hFFE0);
        check("wrap_im", p_im8[0 +: 16], 16'h0000);
`endif
        check("sb9_re", p_re0[0 +: 16], 16'h7FF0);
        idle(2);
        chk_status("post_basic");

        // Overflow and full-FIFO simultaneous push/pop
        do_reset(2);
        set_mant(12'h400, 12'hC00);
        drive(1, 1, 2, 0);
        drive(1, 3, 4, 0);
        drive(1, 5, 6, 0);
        drive(1, 7, 8, 0);
        chk_status("fill");
        drive(1, 9, 10, 1);
        chk_status("full_pushpop");
        drive(1, 11, 12, 0);
        chk_status("ovf");
        for (int i = 0; i < 4; i++) begin
            re_in[0] = 12'(i + 1);
            drive(0, 0, 0, 1);
        end
        idle(3);
        chk_status("drain4");

        // Underflow with a simultaneous push
        do_reset(2);
        set_mant(12'h7FF, 12'h801);
        drive(1, 5, 6, 1);
        @(negedge clk);
        check("unf_re0", p_re0[0 +: 16], 16'h7FF0);
        chk_status("unf");
        idle(2);

        // Reset while a block is in flight
        drive(1, 2, 2, 0);
        drive(0, 0, 0, 1);
        do_reset(2);
        idle(5);
        chk_status("midrst");

        // Random back-to-back traffic
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < ARRAY; i++) begin
                re_in[i] = 12'($urandom);
                im_in[i] = 12'($urandom);
            end
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 24), $urandom_range(0, 24),
                  (idx_q.size() > 0) ? 1'($urandom_range(0, 3) != 0) : 1'b0);
        end
        idle(4);
        chk_status("rand");
        check("drain", sq0.size() + sq8.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
